// File: rtl/eth_cmd_decoder.sv
// Ethernet command decoder: buffers a 64-byte payload in a local packet RAM,
// parses {MAGIC, N, N x {addr, data_hi, data_lo}} and issues config-bus writes.
module eth_cmd_decoder #(
  parameter logic [7:0] MAGIC      = 8'h47,
  parameter int         MAX_WRITES = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  eth_rx_addr,
  input  logic [7:0]  eth_rx_wdata,
  input  logic        eth_rx_we,
  input  logic        eth_rx_ready,
  output logic        eth_rx_read,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  input  logic        reg_busy,
  output logic [15:0] cmd_count,
  output logic [15:0] err_count
);

  localparam int CW = $clog2(MAX_WRITES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_MAGIC, S_COUNT, S_ADDR, S_DHI, S_DLO, S_ISSUE, S_RELEASE, S_DRAIN
  } state_t;

  state_t        state;
  logic [7:0]    mem [64];
  logic [7:0]    rd_data;
  logic [5:0]    rd_addr;
  logic          phase;
  logic [CW-1:0] remaining;
  logic [7:0]    addr_q;
  logic [7:0]    dhi_q;
  logic          fetching;

  // NOTE: the payload RAM and its read register carry no reset; every byte the
  // parser consumes is written by the receiver before eth_rx_ready rises.
  always_ff @(posedge clk) begin
    if (eth_rx_we) mem[eth_rx_addr] <= eth_rx_wdata;
    rd_data <= mem[rd_addr];
  end

  // The strobe is qualified by reg_busy in the same cycle, so a stalled
  // ISSUE releases its write on the very first free cycle.
  assign reg_we = (state == S_ISSUE) && !reg_busy;

  assign fetching = (state == S_MAGIC) || (state == S_COUNT) || (state == S_ADDR) ||
                    (state == S_DHI)   || (state == S_DLO);

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values of phase, rd_addr and remaining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= 1'b0;
      rd_addr     <= '0;
      remaining   <= '0;
      addr_q      <= '0;
      dhi_q       <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      eth_rx_read <= 1'b0;
      cmd_count   <= '0;
      err_count   <= '0;
    end else begin
      // Each byte takes two cycles: present rd_addr, then capture rd_data.
      if (fetching) begin
        phase <= !phase;
        if (phase) rd_addr <= rd_addr + 6'd1;
      end

      case (state)
        S_IDLE: begin
          if (eth_rx_ready) begin
            rd_addr <= '0;
            phase   <= 1'b0;
            state   <= S_MAGIC;
          end
        end
        S_MAGIC: begin
          if (phase) begin
            if (rd_data != MAGIC) begin
              err_count   <= err_count + 16'd1;
              eth_rx_read <= 1'b1;
              state       <= S_RELEASE;
            end else begin
              state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (phase) begin
            if (rd_data > 8'(MAX_WRITES)) begin
              err_count   <= err_count + 16'd1;
              eth_rx_read <= 1'b1;
              state       <= S_RELEASE;
            end else if (rd_data == 8'd0) begin
              cmd_count   <= cmd_count + 16'd1;
              eth_rx_read <= 1'b1;
              state       <= S_RELEASE;
            end else begin
              remaining <= rd_data[CW-1:0];
              state     <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (phase) begin
            addr_q <= rd_data;
            state  <= S_DHI;
          end
        end
        S_DHI: begin
          if (phase) begin
            dhi_q <= rd_data;
            state <= S_DLO;
          end
        end
        S_DLO: begin
          if (phase) begin
            // Address and data are loaded together so they stay coherent
            // for the whole ISSUE stall.
            reg_addr  <= addr_q;
            reg_wdata <= {dhi_q, rd_data};
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!reg_busy) begin
            remaining <= remaining - 1'b1;
            if (remaining == CW'(1)) begin
              cmd_count   <= cmd_count + 16'd1;
              eth_rx_read <= 1'b1;
              state       <= S_RELEASE;
            end else begin
              state <= S_ADDR;
            end
          end
        end
        S_RELEASE: begin
          eth_rx_read <= 1'b0;
          state       <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!eth_rx_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_cmd_decoder.sv
// Directed self-checking bench for eth_cmd_decoder: packet loads, timing of the
// first write, error paths, busy stall and asynchronous reset mid-parse.
module tb_eth_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  eth_rx_addr = '0;
  logic [7:0]  eth_rx_wdata = '0;
  logic        eth_rx_we = 1'b0;
  logic        eth_rx_ready = 1'b0;
  logic        eth_rx_read;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_busy = 1'b0;
  logic [15:0] cmd_count;
  logic [15:0] err_count;

  eth_cmd_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .eth_rx_addr  (eth_rx_addr),
    .eth_rx_wdata (eth_rx_wdata),
    .eth_rx_we    (eth_rx_we),
    .eth_rx_ready (eth_rx_ready),
    .eth_rx_read  (eth_rx_read),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .reg_busy     (reg_busy),
    .cmd_count    (cmd_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_pulses = 0;
  logic [7:0]  log_addr [$];
  logic [15:0] log_data [$];
  logic [7:0]  pkt [64];
  int          lb;
  int          rb;

  // Bus monitor: records every write strobe and buffer release.
  always @(negedge clk) begin
    if (reg_we) begin
      log_addr.push_back(reg_addr);
      log_data.push_back(reg_wdata);
    end
    if (eth_rx_read) rd_pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_read"}, eth_rx_read, 0);
    check({tag, "_reg_we"}, reg_we, 0);
    check({tag, "_reg_addr"}, reg_addr, 0);
    check({tag, "_reg_wdata"}, reg_wdata, 0);
    check({tag, "_cmd_count"}, cmd_count, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  task automatic clear_pkt();
    for (int i = 0; i < 64; i++) pkt[i] = 8'h00;
  endtask

  // Writes all 64 bytes, then raises eth_rx_ready on a falling edge so the
  // next rising edge is edge 0 of the parse.
  task automatic write_ram();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      eth_rx_addr  = 6'(i);
      eth_rx_wdata = pkt[i];
      eth_rx_we    = 1'b1;
    end
    @(negedge clk);
    eth_rx_we    = 1'b0;
    eth_rx_ready = 1'b1;
  endtask

  task automatic wait_read(input string tag, input int base);
    int n = 0;
    while (rd_pulses == base && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_read_seen"}, rd_pulses != base, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic drop_ready();
    eth_rx_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_two_write_pkt();
    clear_pkt();
    pkt[0] = 8'h47; pkt[1] = 8'h02;
    pkt[2] = 8'h10; pkt[3] = 8'h12; pkt[4] = 8'h34;
    pkt[5] = 8'h11; pkt[6] = 8'hAB; pkt[7] = 8'hCD;
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_n_writes"}, log_addr.size() - lb, 2);
    if (log_addr.size() - lb == 2) begin
      check({tag, "_w0_addr"}, log_addr[lb], 32'h10);
      check({tag, "_w0_data"}, log_data[lb], 32'h1234);
      check({tag, "_w1_addr"}, log_addr[lb+1], 32'h11);
      check({tag, "_w1_data"}, log_data[lb+1], 32'hABCD);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // 1: valid two-write packet with first-strobe timing
    load_two_write_pkt();
    lb = log_addr.size(); rb = rd_pulses;
    write_ram();
    repeat (10) @(posedge clk);
    #1 check("t1_we_edge9", reg_we, 0);
    @(posedge clk);
    #1 check("t1_we_edge10", reg_we, 1);
    check("t1_addr_edge10", reg_addr, 32'h10);
    check("t1_data_edge10", reg_wdata, 32'h1234);
    wait_read("t1", rb);
    check_two_writes("t1");
    check("t1_cmd", cmd_count, 1);
    check("t1_err", err_count, 0);
    check("t1_reads", rd_pulses - rb, 1);
    drop_ready();

    // 2: bad magic, DRAIN holds while ready stays high
    do_reset();
    clear_pkt();
    pkt[0] = 8'h46; pkt[1] = 8'h01; pkt[2] = 8'h22;
    lb = log_addr.size(); rb = rd_pulses;
    write_ram();
    wait_read("t2", rb);
    repeat (20) @(negedge clk);
    check("t2_writes", log_addr.size() - lb, 0);
    check("t2_err", err_count, 1);
    check("t2_cmd", cmd_count, 0);
    check("t2_reads_held", rd_pulses - rb, 1);
    drop_ready();

    // 3a: count above MAX_WRITES
    do_reset();
    clear_pkt();
    pkt[0] = 8'h47; pkt[1] = 8'd21;
    lb = log_addr.size(); rb = rd_pulses;
    write_ram();
    wait_read("t3a", rb);
    check("t3a_writes", log_addr.size() - lb, 0);
    check("t3a_err", err_count, 1);
    check("t3a_cmd", cmd_count, 0);
    drop_ready();

    // 3b: count exactly MAX_WRITES, 62 bytes used
    do_reset();
    clear_pkt();
    pkt[0] = 8'h47; pkt[1] = 8'd20;
    for (int i = 0; i < 20; i++) begin
      pkt[2+3*i] = 8'h20 + 8'(i);
      pkt[3+3*i] = 8'(i);
      pkt[4+3*i] = ~8'(i);
    end
    pkt[62] = 8'hEE; pkt[63] = 8'hEE;
    lb = log_addr.size(); rb = rd_pulses;
    write_ram();
    wait_read("t3b", rb);
    check("t3b_n_writes", log_addr.size() - lb, 20);
    if (log_addr.size() - lb == 20) begin
      for (int i = 0; i < 20; i++) begin
        check($sformatf("t3b_addr%0d", i), log_addr[lb+i], 32'(8'h20 + 8'(i)));
        check($sformatf("t3b_data%0d", i), log_data[lb+i], 32'({8'(i), ~8'(i)}));
      end
    end
    check("t3b_cmd", cmd_count, 1);
    check("t3b_err", err_count, 0);
    drop_ready();

    // 4: zero writes
    do_reset();
    clear_pkt();
    pkt[0] = 8'h47; pkt[1] = 8'h00; pkt[2] = 8'h55;
    lb = log_addr.size(); rb = rd_pulses;
    write_ram();
    wait_read("t4", rb);
    check("t4_writes", log_addr.size() - lb, 0);
    check("t4_cmd", cmd_count, 1);
    check("t4_err", err_count, 0);
    check("t4_reads", rd_pulses - rb, 1);
    drop_ready();

    // 5: reg_busy high for the first 7 cycles of the first ISSUE
    do_reset();
    load_two_write_pkt();
    reg_busy = 1'b1;
    lb = log_addr.size(); rb = rd_pulses;
    write_ram();
    repeat (11) @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      #1;
      check($sformatf("t5_stall_we%0d", k), reg_we, 0);
      check($sformatf("t5_stall_addr%0d", k), reg_addr, 32'h10);
      check($sformatf("t5_stall_data%0d", k), reg_wdata, 32'h1234);
      if (k < 6) @(posedge clk);
    end
    reg_busy = 1'b0;
    #1 check("t5_we_release", reg_we, 1);
    wait_read("t5", rb);
    check_two_writes("t5");
    check("t5_cmd", cmd_count, 1);
    drop_ready();

    // 6: asynchronous reset while in DHI of the second triple
    load_two_write_pkt();
    write_ram();
    repeat (14) @(posedge clk);
    #1 check("t6_pre_addr", reg_addr, 32'h10);
    check("t6_pre_cmd", cmd_count, 1);
    reset = 1'b1;
    #1 check_reset_outputs("t6_async");
    @(negedge clk);
    @(negedge clk);
    lb = log_addr.size(); rb = rd_pulses;
    reset = 1'b0;
    wait_read("t6", rb);
    check_two_writes("t6");
    check("t6_cmd", cmd_count, 1);
    check("t6_err", err_count, 0);
    check("t6_reads", rd_pulses - rb, 1);
    drop_ready();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_cmd_decoder.md
Name: eth_cmd_decoder

Overview:
Consumes the 64-byte payload that the Ethernet receiver deposits through its packet-RAM write port. Holds a 64x8 packet RAM, parses the command once the receiver flags the packet ready, and issues 16-bit register writes on the front-end config bus. Returns the buffer to the receiver with an eth_rx_read pulse and keeps good/bad packet counters for the status readback.

Parameters:
MAGIC, 8'h47, required value of payload byte 0
MAX_WRITES, 20, maximum register writes per packet (2+3*20=62 <= 64 bytes)

Ports:
clk  in  1  system clock (receiver clock domain)
reset  in  1  asynchronous, active-high reset
eth_rx_addr  in  6  packet RAM write address from receiver
eth_rx_wdata  in  8  packet RAM write data
eth_rx_we  in  1  packet RAM write enable
eth_rx_ready  in  1  receiver has a complete 64-byte payload in RAM
eth_rx_read  out  1  one-cycle pulse: payload consumed, receiver may reuse RAM
reg_addr  out  8  config register address
reg_wdata  out  16  config register data
reg_we  out  1  one-cycle write strobe
reg_busy  in  1  config bus cannot accept a write this cycle
cmd_count  out  16  packets executed successfully, wraps at 16'hFFFF -> 0
err_count  out  16  packets rejected, wraps

Behaviour:
- Reset values: eth_rx_read=0, reg_we=0, reg_addr=0, reg_wdata=0, cmd_count=0, err_count=0, state=IDLE. RAM contents are not reset.
- RAM: write on clk when eth_rx_we; synchronous read, data valid one cycle after rd_addr. Decoder reads only while eth_rx_ready=1, when the receiver no longer writes.
- Packet format: byte0=MAGIC, byte1=N (write count), then N triples {addr, data[15:8], data[7:0]}. Bytes past 2+3N are ignored.
- Byte fetch: exactly 2 cycles (present address, capture data).
- States: IDLE, MAGIC, COUNT, ADDR, DHI, DLO, ISSUE, RELEASE, DRAIN.
- IDLE: eth_rx_ready=1 sampled at edge 0 -> rd_addr=0 -> MAGIC.
- Edge timing: byte0 captured at edge 2, byte1 at edge 4. First triple is captured at edges 6, 8 and 10; reg_we is high in the cycle after edge 10 if reg_busy=0.
- MAGIC: byte != MAGIC -> err_count+1, RELEASE.
- COUNT: N > MAX_WRITES -> err_count+1, RELEASE. N=0 -> cmd_count+1, RELEASE. Otherwise latch N and go to ADDR.
- ADDR/DHI/DLO: assemble reg_addr and reg_wdata, then go to ISSUE.
- ISSUE: while reg_busy=1, hold and keep reg_we=0. On a cycle with reg_busy=0, assert reg_we for exactly one cycle and decrement the remaining count.
  - Remaining count not zero: fetch the next triple; at most one reg_we per triple.
  - Remaining count zero: cmd_count+1, RELEASE.
- reg_addr and reg_wdata stay stable from the cycle before reg_we until the next triple is loaded.
- RELEASE: eth_rx_read=1 for one cycle, then DRAIN.
- DRAIN: wait until eth_rx_ready=0, then IDLE. This prevents re-parsing the same buffer while the receiver clears ready.
- eth_rx_ready falling mid-parse is not expected. If it happens, the packet completes from the existing RAM contents.
- Counter increment and eth_rx_read entry share the same edge. The two counters never increment in the same cycle.
- Reset mid-operation (any state): outputs return to reset values immediately (async). A packet left ready in the receiver is re-parsed from IDLE after reset release.
- eth_rx_we during a parse is ignored by the FSM; the RAM write still happens.

Test Plan:
1. Valid 2-write packet [47,02, 10,12,34, 11,AB,CD]:
   - reg_we pulses with (10,1234) then (11,ABCD); first reg_we in the cycle after edge 10.
   - cmd_count=1, then one eth_rx_read pulse.
2. Bad magic (byte0=46):
   - no reg_we; err_count=1; eth_rx_read pulses once.
   - DRAIN holds until eth_rx_ready drops.
3. Out-of-range count, N=21:
   - no reg_we; err_count=1.
   - N=20 with 62 bytes: exactly 20 reg_we pulses; cmd_count=1.
4. N=0:
   - no reg_we; cmd_count=1; eth_rx_read pulses once.
5. reg_busy stall, busy high for 7 cycles at the first ISSUE:
   - reg_we is delayed until the first busy-low cycle.
   - reg_addr/reg_wdata unchanged throughout; still one pulse per triple.
6. reset asserted during DHI:
   - all outputs go to zero asynchronously.
   - After release with eth_rx_ready=1, the packet is parsed fully once; cmd_count=1.
